// File: rtl/mips_hazard_stall_ctrl.sv
// mips_hazard_stall_ctrl
// ----------------------
// Pipeline front-end stall/flush controller for a 5-stage MIPS core.
// It combines load-use stalls, taken-branch redirects and multi-cycle
// multiply/divide freezes into PC / IF-ID / ID-EX control signals.
// All control outputs are combinational from the current state, the counter
// and the current inputs, so a stall takes effect in the cycle it is requested.
//
// Parameters
//   MUL_CYCLES  front-end freeze length for a multiply (1..64)
//   DIV_CYCLES  front-end freeze length for a divide   (1..64)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   stallLwRead  load-use stall request (same cycle)
//   mdStart      ID holds a mul/div issue request
//   mdOp         0 = multiply, 1 = divide (sampled with mdStart)
//   branchTaken  EX resolved a taken branch/jump this cycle
//   pcWrite      PC load enable
//   ifIdWrite    IF/ID load enable
//   ifIdFlush    clear IF/ID to NOP
//   idExBubble   load NOP into ID/EX
//   mdBusy       high while the mul/div freeze is running
//   mdDone       one-cycle pulse in the final freeze cycle
//   stallCount   (only with MIPS_HAZARD_STALL_STATS_EN) saturating count of
//                cycles with pcWrite=0, cleared by reset
//   dbg_state    current FSM state (0 = RUN, 1 = MD_WAIT)
//
// Handshake: there is no valid/ready pair here. Requests are level inputs
// evaluated every cycle; the controller answers in the same cycle through
// the enable/flush/bubble outputs. A requester whose ID instruction is held
// (pcWrite=0, ifIdWrite=0) simply keeps its request asserted.
//
// Optional feature macro: MIPS_HAZARD_STALL_STATS_EN adds the stallCount port.

module mips_hazard_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallLwRead,
  input  logic        mdStart,
  input  logic        mdOp,
  input  logic        branchTaken,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        ifIdFlush,
  output logic        idExBubble,
  output logic        mdBusy,
  output logic        mdDone,
`ifdef MIPS_HAZARD_STALL_STATS_EN
  output logic [31:0] stallCount,
`endif
  output logic        dbg_state
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // The freeze starts in the cycle after issue and ends when cnt reaches 0,
  // so loading N-1 yields exactly N frozen cycles.
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state, state_next;
  logic [5:0] cnt, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 6'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    mdBusy     = 1'b0;
    mdDone     = 1'b0;

    case (state)
      RUN: begin
        if (branchTaken) begin
          // Redirect squashes whatever is in IF and ID, so competing
          // requests from the wrong-path instruction are dropped.
          ifIdFlush  = 1'b1;
          idExBubble = 1'b1;
        end else if (stallLwRead) begin
          // Hold ID; a pending mul/div is re-presented next cycle.
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          idExBubble = 1'b1;
        end else if (mdStart) begin
          // The mul/div itself advances to EX this cycle; freeze after.
          state_next = MD_WAIT;
          cnt_next   = mdOp ? DIV_LOAD : MUL_LOAD;
        end
      end

      MD_WAIT: begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
        mdBusy     = 1'b1;
        if (cnt == 6'd0) begin
          mdDone     = 1'b1;
          state_next = RUN;
        end else begin
          cnt_next = cnt - 6'd1;
        end
        // A redirect from an older instruction still in EX must win over
        // the freeze; counting continues unaffected.
        if (branchTaken) begin
          pcWrite   = 1'b1;
          ifIdFlush = 1'b1;
        end
      end

      default: begin
        state_next = RUN;
        cnt_next   = 6'd0;
      end
    endcase

    // Outputs take their idle values while reset is held, whatever the inputs.
    if (!rst_n) begin
      pcWrite    = 1'b1;
      ifIdWrite  = 1'b1;
      ifIdFlush  = 1'b0;
      idExBubble = 1'b0;
      mdBusy     = 1'b0;
      mdDone     = 1'b0;
    end
  end

  assign dbg_state = state;

`ifdef MIPS_HAZARD_STALL_STATS_EN
  logic [31:0] stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 32'd0;
    end else if (!pcWrite && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  assign stallCount = stall_count;
`endif

endmodule

// File: tb/tb_mips_hazard_stall_ctrl.sv
// Directed testbench for mips_hazard_stall_ctrl (default parameters).
// Output vector layout used throughout:
//   {pcWrite, ifIdWrite, ifIdFlush, idExBubble, mdBusy, mdDone}

module tb_mips_hazard_stall_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic stallLwRead, mdStart, mdOp, branchTaken;
  logic pcWrite, ifIdWrite, ifIdFlush, idExBubble, mdBusy, mdDone;
  logic dbg_state;
`ifdef MIPS_HAZARD_STALL_STATS_EN
  logic [31:0] stallCount;
`endif

  mips_hazard_stall_ctrl #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stallLwRead (stallLwRead),
    .mdStart     (mdStart),
    .mdOp        (mdOp),
    .branchTaken (branchTaken),
    .pcWrite     (pcWrite),
    .ifIdWrite   (ifIdWrite),
    .ifIdFlush   (ifIdFlush),
    .idExBubble  (idExBubble),
    .mdBusy      (mdBusy),
    .mdDone      (mdDone),
`ifdef MIPS_HAZARD_STALL_STATS_EN
    .stallCount  (stallCount),
`endif
    .dbg_state   (dbg_state)
  );

  // Hand-computed output patterns
  localparam logic [5:0] O_RUN    = 6'b110000; // normal flow / reset values
  localparam logic [5:0] O_LW     = 6'b000100; // load-use stall
  localparam logic [5:0] O_BR     = 6'b111100; // branch redirect in RUN
  localparam logic [5:0] O_WAIT   = 6'b000110; // mul/div freeze
  localparam logic [5:0] O_DONE   = 6'b000111; // last freeze cycle
  localparam logic [5:0] O_WAITBR = 6'b101110; // redirect during freeze

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [5:0] exp_q[$];

  function automatic logic [5:0] outs();
    return {pcWrite, ifIdWrite, ifIdFlush, idExBubble, mdBusy, mdDone};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Apply one cycle's inputs at the falling edge, then settle 1ns so the
  // combinational outputs can be sampled well before the rising edge.
  task automatic drive(input logic rv, input logic bt, input logic lw,
                       input logic ms, input logic op);
    @(negedge clk);
    rst_n       = rv;
    branchTaken = bt;
    stallLwRead = lw;
    mdStart     = ms;
    mdOp        = op;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; branchTaken = 1'b0; stallLwRead = 1'b0; mdStart = 1'b0; mdOp = 1'b0;
    #2;
    check("reset_outs", 32'(outs()), 32'(O_RUN));
    check("reset_state", 32'(dbg_state), 32'd0);
    // Requests while reset is held must not affect outputs or state.
    branchTaken = 1'b1; stallLwRead = 1'b1; mdStart = 1'b1;
    #1;
    check("reset_outs_inputs_active", 32'(outs()), 32'(O_RUN));
    @(posedge clk); #1;
    check("reset_no_md_entry", 32'(dbg_state), 32'd0);

    // Load-use stall right after reset release, then normal flow.
    drive(1, 0, 1, 0, 0);
    check("lw_stall", 32'(outs()), 32'(O_LW));
    drive(1, 0, 0, 0, 0);
    check("lw_after", 32'(outs()), 32'(O_RUN));

    // branchTaken beats stallLwRead and mdStart.
    drive(1, 1, 1, 1, 1);
    check("prio_branch", 32'(outs()), 32'(O_BR));
    drive(1, 0, 0, 0, 0);
    check("prio_branch_no_md", 32'(outs()), 32'(O_RUN));
    check("prio_branch_state", 32'(dbg_state), 32'd0);

    // stallLwRead beats mdStart.
    drive(1, 0, 1, 1, 0);
    check("prio_lw", 32'(outs()), 32'(O_LW));
    drive(1, 0, 0, 0, 0);
    check("prio_lw_no_md", 32'(outs()), 32'(O_RUN));

    // Divide: 32 frozen cycles, mdStart/stallLwRead ignored throughout.
    drive(1, 0, 0, 1, 1);
    check("div_issue", 32'(outs()), 32'(O_RUN));
    for (int i = 0; i < 32; i++) exp_q.push_back((i == 31) ? O_DONE : O_WAIT);
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 1, 1, 1);
      check($sformatf("div_wait_%0d", i), 32'(outs()), 32'(exp_q.pop_front()));
    end
    drive(1, 0, 0, 0, 0);
    check("div_after", 32'(outs()), 32'(O_RUN));
    check("div_after_state", 32'(dbg_state), 32'd0);

    // Multiply with a redirect in the 3rd wait cycle.
    drive(1, 0, 0, 1, 0);
    check("mul_issue", 32'(outs()), 32'(O_RUN));
    drive(1, 0, 0, 0, 0);
    check("mul_w1", 32'(outs()), 32'(O_WAIT));
    drive(1, 0, 0, 0, 0);
    check("mul_w2", 32'(outs()), 32'(O_WAIT));
    drive(1, 1, 0, 0, 0);
    check("mul_w3_branch", 32'(outs()), 32'(O_WAITBR));
    drive(1, 0, 0, 0, 0);
    check("mul_w4_done", 32'(outs()), 32'(O_DONE));
    drive(1, 0, 0, 0, 0);
    check("mul_after", 32'(outs()), 32'(O_RUN));

    // Asynchronous reset in the 2nd multiply wait cycle.
    drive(1, 0, 0, 1, 0);
    check("rst_mul_issue", 32'(outs()), 32'(O_RUN));
    drive(1, 0, 0, 0, 0);
    check("rst_mul_w1", 32'(outs()), 32'(O_WAIT));
    drive(1, 0, 0, 0, 0);
    check("rst_mul_w2", 32'(outs()), 32'(O_WAIT));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", 32'(outs()), 32'(O_RUN));
    check("async_rst_state", 32'(dbg_state), 32'd0);
    drive(1, 0, 0, 0, 0);
    check("rst_release_1", 32'(outs()), 32'(O_RUN));
    drive(1, 0, 0, 0, 0);
    check("rst_release_2", 32'(outs()), 32'(O_RUN));

    // One lw stall plus one 4-cycle multiply: five pcWrite=0 cycles.
    drive(1, 0, 1, 0, 0);
    check("stat_lw", 32'(outs()), 32'(O_LW));
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0);
      check($sformatf("stat_w%0d", i), 32'(outs()), 32'((i == 3) ? O_DONE : O_WAIT));
    end
    drive(1, 0, 0, 0, 0);
    check("stat_after", 32'(outs()), 32'(O_RUN));
`ifdef MIPS_HAZARD_STALL_STATS_EN
    check("stall_count", stallCount, 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
